// File: rtl/scrambler_os_sched.sv
`default_nettype none
// ============================================================================
// Module      : scrambler_os_sched
// Description : Transmit symbol scheduler in front of the 8-bit scrambler.
//               Emits one symbol per clock and inserts COM+SKP ordered sets.
// Revision    : 1.0 - initial release
// ============================================================================
module scrambler_os_sched #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_LEN      = 3,
    parameter logic [7:0]  IDLE_DATA    = 8'h00
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  in_data,
    input  logic        in_k,
    input  logic        in_valid,
    input  logic        in_frame,
    output logic        in_ready,
    input  logic        cfg_disab_scram,
    output logic [7:0]  out_data,
    output logic        out_k,
    output logic        out_disab_scram,
    output logic        skp_active,
    output logic [15:0] skp_os_cnt,
    output logic        proto_err
);

    localparam logic [7:0]  c_COM          = 8'hBC;
    localparam logic [7:0]  c_SKP          = 8'h1C;
    localparam logic [15:0] c_SKP_INTERVAL = 16'(SKP_INTERVAL);
    localparam logic [3:0]  c_BODY_LAST    = 4'(SKP_LEN - 1);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_DATA     = 2'd1,
        S_SKP_BODY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_sym_cnt;
    logic [15:0] w_sym_cnt_nxt;
    logic [3:0]  r_body_cnt;
    logic [3:0]  w_body_cnt_nxt;

    logic        w_pending;
    logic        w_start_os;
    logic        w_accept;
    logic        w_proto_hit;
    logic        w_os_inc;
    logic [7:0]  w_data;
    logic        w_k;
    logic        w_skp;
    logic        w_disab;

    assign w_pending   = (r_sym_cnt == c_SKP_INTERVAL);
    assign w_start_os  = (r_state == S_DATA) && w_pending && !in_frame;
    assign in_ready    = (r_state == S_DATA) && !w_start_os;
    assign w_accept    = in_valid && in_ready;
    // Reserved K codes are still forwarded; only the sticky flag records them.
    assign w_proto_hit = w_accept && in_k && ((in_data == c_COM) || (in_data == c_SKP));

    always_comb begin
        w_state_nxt    = r_state;
        w_sym_cnt_nxt  = r_sym_cnt;
        w_body_cnt_nxt = r_body_cnt;
        w_data         = IDLE_DATA;
        w_k            = 1'b0;
        w_skp          = 1'b0;
        w_disab        = out_disab_scram;
        w_os_inc       = 1'b0;
        case (r_state)
            S_INIT: begin
                w_data        = c_COM;
                w_k           = 1'b1;
                w_skp         = 1'b1;
                w_disab       = cfg_disab_scram;
                w_sym_cnt_nxt = 16'd0;
                w_state_nxt   = S_DATA;
            end
            S_DATA: begin
                if (w_start_os) begin
                    w_data         = c_COM;
                    w_k            = 1'b1;
                    w_skp          = 1'b1;
                    w_disab        = cfg_disab_scram;
                    w_sym_cnt_nxt  = 16'd0;
                    w_body_cnt_nxt = 4'd0;
                    w_os_inc       = 1'b1;
                    w_state_nxt    = S_SKP_BODY;
                end else begin
                    if (w_accept) begin
                        w_data = in_data;
                        w_k    = in_k;
                    end
                    // Saturate so a deferred insertion stays pending through a frame.
                    if (!w_pending) begin
                        w_sym_cnt_nxt = r_sym_cnt + 16'd1;
                    end
                end
            end
            S_SKP_BODY: begin
                w_data         = c_SKP;
                w_k            = 1'b1;
                w_skp          = 1'b1;
                w_body_cnt_nxt = r_body_cnt + 4'd1;
                if (r_body_cnt == c_BODY_LAST) begin
                    w_state_nxt = S_DATA;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state         <= S_INIT;
            r_sym_cnt       <= 16'd0;
            r_body_cnt      <= 4'd0;
            out_data        <= 8'h00;
            out_k           <= 1'b0;
            out_disab_scram <= 1'b0;
            skp_active      <= 1'b0;
            skp_os_cnt      <= 16'd0;
            proto_err       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_sym_cnt       <= w_sym_cnt_nxt;
            r_body_cnt      <= w_body_cnt_nxt;
            out_data        <= w_data;
            out_k           <= w_k;
            out_disab_scram <= w_disab;
            skp_active      <= w_skp;
            if (w_os_inc) begin
                skp_os_cnt <= skp_os_cnt + 16'd1;
            end
            if (w_proto_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
